// File: rtl/i2s_receiver.sv
// I2S receiver: captures MSB-first left/right words from a codec serial
// stream that is asynchronous to clk and presents them as a word pair.
// All codec inputs are resynchronised; state only advances on rising
// edges of the synchronised bit clock.
module i2s_receiver #(
    parameter int SAMPLE_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    audio_lrck,
    input  logic                    audio_sck,
    input  logic                    audio_sdout,
    output logic [SAMPLE_WIDTH-1:0] sample_left,
    output logic [SAMPLE_WIDTH-1:0] sample_right,
    output logic                    sample_valid,
    output logic                    frame_err
);

    localparam int CW = $clog2(SAMPLE_WIDTH + 1);

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_DELAY = 2'd1,
        ST_SHIFT = 2'd2,
        ST_PAD   = 2'd3
    } state_t;

    // Synchronizer chains; sck carries one extra stage for edge detection.
    logic lr_s1_q, lr_s2_q;
    logic sd_s1_q, sd_s2_q;
    logic sck_s1_q, sck_s2_q, sck_s3_q;

    // Receiver state.
    state_t                  state_q;
    logic                    chan_q;      // 0 = left word being received, 1 = right
    logic                    prev_lr_q;   // lrck as sampled at the previous bit event
    logic [CW-1:0]           count_q;
    logic [SAMPLE_WIDTH-1:0] shift_q;
    logic [SAMPLE_WIDTH-1:0] staging_q;   // completed left word awaiting its right partner
    logic                    left_ok_q;
    logic                    pair_pend_q; // pair loaded this cycle, valid follows next cycle

    // Registered outputs.
    logic [SAMPLE_WIDTH-1:0] sample_left_q;
    logic [SAMPLE_WIDTH-1:0] sample_right_q;
    logic                    sample_valid_q;
    logic                    frame_err_q;

    // Combinational helpers derived from the synchronised inputs.
    logic                    bit_evt;
    logic                    lr_change;
    logic                    word_done;
    logic [SAMPLE_WIDTH-1:0] shift_d;

    // Resynchronise the codec signals into the clk domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            lr_s1_q  <= 1'b0;
            lr_s2_q  <= 1'b0;
            sd_s1_q  <= 1'b0;
            sd_s2_q  <= 1'b0;
            sck_s1_q <= 1'b0;
            sck_s2_q <= 1'b0;
            sck_s3_q <= 1'b0;
        end else begin
            lr_s1_q  <= audio_lrck;
            lr_s2_q  <= lr_s1_q;
            sd_s1_q  <= audio_sdout;
            sd_s2_q  <= sd_s1_q;
            sck_s1_q <= audio_sck;
            sck_s2_q <= sck_s1_q;
            sck_s3_q <= sck_s2_q;
        end
    end

    // Decode bit events, channel changes and the next shift-register value.
    always_comb begin
        bit_evt   = sck_s2_q & ~sck_s3_q;
        lr_change = (lr_s2_q != prev_lr_q);
        word_done = (count_q == CW'(SAMPLE_WIDTH - 1));
        shift_d   = {shift_q[SAMPLE_WIDTH-2:0], sd_s2_q};
    end

    // Frame-tracking FSM: word capture, left/right pairing and output pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_SYNC;
            chan_q         <= 1'b0;
            prev_lr_q      <= 1'b0;
            count_q        <= '0;
            shift_q        <= '0;
            staging_q      <= '0;
            left_ok_q      <= 1'b0;
            pair_pend_q    <= 1'b0;
            sample_left_q  <= '0;
            sample_right_q <= '0;
            sample_valid_q <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            // Pulses last exactly one cycle unless re-armed below.
            frame_err_q    <= 1'b0;
            pair_pend_q    <= 1'b0;
            sample_valid_q <= pair_pend_q;

            if (bit_evt) begin
                prev_lr_q <= lr_s2_q;
                case (state_q)
                    ST_SYNC: begin
                        // Wait for the first slot boundary before trusting alignment.
                        if (lr_change) begin
                            state_q <= ST_DELAY;
                            chan_q  <= lr_s2_q;
                        end else begin
                            state_q <= ST_SYNC;
                        end
                    end

                    ST_DELAY: begin
                        // The one-bit I2S delay slot carries no data for this word.
                        state_q <= ST_SHIFT;
                        count_q <= '0;
                    end

                    ST_SHIFT: begin
                        if (lr_change) begin
                            // Slot ended early: drop the partial word and any pending left.
                            frame_err_q <= 1'b1;
                            left_ok_q   <= 1'b0;
                            chan_q      <= lr_s2_q;
                            count_q     <= '0;
                            state_q     <= ST_DELAY;
                        end else begin
                            shift_q <= shift_d;
                            if (word_done) begin
                                count_q <= CW'(SAMPLE_WIDTH);
                                state_q <= ST_PAD;
                                if (!chan_q) begin
                                    staging_q <= shift_d;
                                    left_ok_q <= 1'b1;
                                end else if (left_ok_q) begin
                                    sample_left_q  <= staging_q;
                                    sample_right_q <= shift_d;
                                    pair_pend_q    <= 1'b1;
                                    left_ok_q      <= 1'b0;
                                end else begin
                                    // Right word without a left partner is discarded.
                                    left_ok_q <= 1'b0;
                                end
                            end else begin
                                count_q <= count_q + CW'(1);
                            end
                        end
                    end

                    ST_PAD: begin
                        // Remaining slot bits (e.g. low bits of wider words) are ignored.
                        if (lr_change) begin
                            state_q <= ST_DELAY;
                            chan_q  <= lr_s2_q;
                        end else begin
                            state_q <= ST_PAD;
                        end
                    end

                    default: begin
                        state_q <= ST_SYNC;
                    end
                endcase
            end
        end
    end

    assign sample_left  = sample_left_q;
    assign sample_right = sample_right_q;
    assign sample_valid = sample_valid_q;
    assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_i2s_receiver.sv
// Bench for i2s_receiver: an I2S transmitter model drives 32-sck slots at
// sck = clk/8. Within a slot, period 0 carries the channel change, period 1
// is the delay bit, and periods 2.. carry the 24-bit data MSB first, so a
// 16-bit receiver keeps the top 16 bits. Expected pairs go into a queue when
// a frame is sent and are popped when sample_valid is seen.
module tb_i2s_receiver;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         lrck;
    logic         sck;
    logic         sdout;
    logic [W-1:0] sl;
    logic [W-1:0] sr;
    logic         sv;
    logic         fe;

    always #5 clk = ~clk;

    i2s_receiver #(.SAMPLE_WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .audio_lrck   (lrck),
        .audio_sck    (sck),
        .audio_sdout  (sdout),
        .sample_left  (sl),
        .sample_right (sr),
        .sample_valid (sv),
        .frame_err    (fe)
    );

    typedef struct {
        logic [23:0] l_data;
        logic [23:0] r_data;
        logic [15:0] exp_l;
        logic [15:0] exp_r;
    } vec_t;

    int          checks    = 0;
    int          failures  = 0;
    int          valid_cnt = 0;
    int          ferr_cnt  = 0;
    logic [31:0] exp_q[$];
    logic        prev_sv   = 1'b0;
    logic        prev_fe   = 1'b0;
    logic [W-1:0] prev_sl  = '0;
    logic [W-1:0] prev_sr  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Output monitor: scoreboard pops on each valid pulse, pulse widths checked.
    always @(negedge clk) begin
        logic [31:0] pair;
        if (sv) begin
            valid_cnt++;
            check("valid_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                pair = exp_q.pop_front();
                check("sample_left", 32'(sl), 32'(pair[31:16]));
                check("sample_right", 32'(sr), 32'(pair[15:0]));
            end
            check("valid_data_stable", {sl, sr}, {prev_sl, prev_sr});
            check("valid_single_cycle", 32'(prev_sv), 32'd0);
        end
        if (fe) begin
            ferr_cnt++;
            check("ferr_single_cycle", 32'(prev_fe), 32'd0);
        end
        prev_sv <= sv;
        prev_fe <= fe;
        prev_sl <= sl;
        prev_sr <= sr;
    end

    task automatic check_zero_outputs(input string tag);
        check({tag, "_left"}, 32'(sl), 32'd0);
        check({tag, "_right"}, 32'(sr), 32'd0);
        check({tag, "_valid"}, 32'(sv), 32'd0);
        check({tag, "_ferr"}, 32'(fe), 32'd0);
    endtask

    // One sck period: data/lrck change with sck low, 4 clk low then 4 clk high.
    task automatic sck_period(input logic lr, input logic b, input bit do_pulse);
        @(negedge clk);
        sck   = 1'b0;
        lrck  = lr;
        sdout = b;
        if (do_pulse) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check_zero_outputs("rst_pulse");
            repeat (3) @(negedge clk);
        end else begin
            repeat (4) @(negedge clk);
        end
        sck = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_slot(input logic lr, input logic [31:0] bits, input int nper,
                             input int pulse_at, input int release_at);
        for (int k = 0; k < nper; k++) begin
            if (k == release_at) rst = 1'b0;
            sck_period(lr, bits[31-k], k == pulse_at);
        end
    endtask

    function automatic logic [31:0] mk_slot(input logic [23:0] d);
        logic [1:0] junk;
        logic [5:0] pad;
        junk = 2'($urandom_range(0, 3));
        pad  = 6'($urandom_range(0, 63));
        return {junk, d, pad};
    endfunction

    task automatic send_frame(input logic [23:0] l, input logic [23:0] r);
        send_slot(1'b0, mk_slot(l), 32, -1, -1);
        send_slot(1'b1, mk_slot(r), 32, -1, -1);
    endtask

    initial begin
        vec_t        tbl[5];
        int          v0;
        int          f0;
        logic [23:0] l;
        logic [23:0] r;
        logic [15:0] last_l;
        logic [15:0] last_r;

        tbl[0] = '{24'hA5C300, 24'h123400, 16'hA5C3, 16'h1234};
        tbl[1] = '{24'h7FFF01, 24'h800002, 16'h7FFF, 16'h8000};
        tbl[2] = '{24'h000000, 24'hFFFFFF, 16'h0000, 16'hFFFF};
        tbl[3] = '{24'h8000FF, 24'h7FFF00, 16'h8000, 16'h7FFF};
        tbl[4] = '{24'h5555AA, 24'hAAAA55, 16'h5555, 16'hAAAA};

        rst   = 1'b1;
        sck   = 1'b0;
        lrck  = 1'b0;
        sdout = 1'b0;
        repeat (4) @(negedge clk);
        check_zero_outputs("reset");
        rst = 1'b0;

        // A lone right slot establishes alignment; no left partner, so no pair.
        v0 = valid_cnt;
        send_slot(1'b1, mk_slot(24'h135790), 32, -1, -1);
        check("sync_slot_no_valid", 32'(valid_cnt - v0), 32'd0);

        last_l = 16'h0;
        last_r = 16'h0;
        for (int i = 0; i < 5; i++) begin
            v0 = valid_cnt;
            exp_q.push_back({tbl[i].exp_l, tbl[i].exp_r});
            send_frame(tbl[i].l_data, tbl[i].r_data);
            check("tbl_valid_count", 32'(valid_cnt - v0), 32'd1);
            check("tbl_queue_drained", 32'(exp_q.size()), 32'd0);
            last_l = tbl[i].exp_l;
            last_r = tbl[i].exp_r;
        end

        // LRCK toggles after 8 left bits: one frame error, no pair, outputs held.
        v0 = valid_cnt;
        f0 = ferr_cnt;
        send_slot(1'b0, mk_slot(24'h3C3C00), 10, -1, -1);
        send_slot(1'b1, mk_slot(24'h0F0F00), 32, -1, -1);
        check("trunc_ferr_count", 32'(ferr_cnt - f0), 32'd1);
        check("trunc_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("trunc_hold_left", 32'(sl), 32'(last_l));
        check("trunc_hold_right", 32'(sr), 32'(last_r));
        v0 = valid_cnt;
        exp_q.push_back({16'h2468, 16'h9BDF});
        send_frame(24'h246800, 24'h9BDF00);
        check("trunc_recover_valid", 32'(valid_cnt - v0), 32'd1);

        // One-cycle reset mid left word; the partial frame yields nothing.
        v0 = valid_cnt;
        send_slot(1'b0, mk_slot(24'hC0DE00), 32, 8, -1);
        send_slot(1'b1, mk_slot(24'hBEEF00), 32, -1, -1);
        check("midrst_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("midrst_left_zero", 32'(sl), 32'd0);
        v0 = valid_cnt;
        exp_q.push_back({16'h4321, 16'h8765});
        send_frame(24'h432100, 24'h876500);
        check("midrst_recover_valid", 32'(valid_cnt - v0), 32'd1);

        // Reset released in the middle of a right slot, then a full frame.
        v0 = valid_cnt;
        rst = 1'b1;
        send_slot(1'b1, mk_slot(24'hFEDCBA), 32, -1, 12);
        check("relrst_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("relrst_left_zero", 32'(sl), 32'd0);
        check("relrst_right_zero", 32'(sr), 32'd0);
        exp_q.push_back({16'h0001, 16'hFFFF});
        send_frame(24'h000100, 24'hFFFF00);
        check("relrst_valid", 32'(valid_cnt - v0), 32'd1);

        // No sck activity: nothing moves.
        v0 = valid_cnt;
        f0 = ferr_cnt;
        repeat (300) @(negedge clk);
        check("idle_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("idle_no_ferr", 32'(ferr_cnt - f0), 32'd0);
        check("idle_hold_left", 32'(sl), 32'h0001);
        check("idle_hold_right", 32'(sr), 32'hFFFF);

        // 100 random back-to-back frames.
        v0 = valid_cnt;
        f0 = ferr_cnt;
        for (int i = 0; i < 100; i++) begin
            l = 24'($urandom);
            r = 24'($urandom);
            exp_q.push_back({l[23:8], r[23:8]});
            send_frame(l, r);
        end
        check("rand_valid_count", 32'(valid_cnt - v0), 32'd100);
        check("rand_no_ferr", 32'(ferr_cnt - f0), 32'd0);
        check("final_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
